// File: rtl/simon_seq_if.sv
// Bus bundle between the Simon sequencer and its environment.
// The environment covers the start/button inputs, the random byte source and the
// external 32-bit sequence register. It uses the master modport and drives
// start, rand_byte, mem_data and btn. The sequencer uses the slave modport and
// drives the register write strobes, the symbol display outputs and the game status.
interface simon_seq_if;
    logic        start;
    logic [7:0]  rand_byte;
    logic [31:0] mem_data;
    logic [3:0]  btn;
    logic        mem_rst;
    logic        mem_load;
    logic [1:0]  mem_load_val;
    logic [7:0]  mem_in;
    logic        show_valid;
    logic [1:0]  show_sym;
    logic [4:0]  round;
    logic        busy;
    logic        win;
    logic        fail;

    modport master (
        output start, rand_byte, mem_data, btn,
        input  mem_rst, mem_load, mem_load_val, mem_in,
               show_valid, show_sym, round, busy, win, fail
    );

    modport slave (
        input  start, rand_byte, mem_data, btn,
        output mem_rst, mem_load, mem_load_val, mem_in,
               show_valid, show_sym, round, busy, win, fail
    );
endinterface

// File: rtl/simon_seq_ctrl.sv
// Simon Says game sequencer.
// A start request clears the external sequence register and then loads it with
// four random bytes. Each round replays the first N symbols and then checks the
// player's presses. The game is won after MAX_ROUND correct rounds. It fails on
// a wrong press, on a press of more than one button, or on a timeout.
// Ports: clk, rst_n (async, active-low), bus (simon_seq_if.slave).
// Outputs are Moore-decoded from the registered state, idx, round and lane.
// mem_in passes rand_byte through during LOAD.
// show_sym selects its symbol from mem_data during SHOW.
module simon_seq_ctrl #(
    parameter int unsigned SHOW_CYCLES    = 8,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned MAX_ROUND      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic         clk,
    input logic         rst_n,
    simon_seq_if.slave  bus
);
    localparam int unsigned PH_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_SHOW, S_GAP, S_INPUT, S_WIN, S_FAIL
    } state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [3:0]        idx_q, idx_d;
    logic [4:0]        round_q, round_d;
    logic [1:0]        lane_q, lane_d;

    logic [1:0]        exp_sym;
    logic              more;

    // Symbol currently displayed or expected, and whether it is not the last of the round
    assign exp_sym = bus.mem_data[{idx_q, 1'b0} +: 2];
    assign more    = (5'({1'b0, idx_q}) + 5'd1) < round_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            to_q    <= '0;
            idx_q   <= '0;
            round_q <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            to_q    <= to_d;
            idx_q   <= idx_d;
            round_q <= round_d;
            lane_q  <= lane_d;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        to_d    = to_q;
        idx_d   = idx_q;
        round_d = round_q;
        lane_d  = lane_q;

        bus.mem_rst      = 1'b0;
        bus.mem_load     = 1'b0;
        bus.mem_load_val = 2'd0;
        bus.mem_in       = 8'd0;
        bus.show_valid   = 1'b0;
        bus.show_sym     = 2'd0;
        bus.round        = round_q;
        bus.busy         = 1'b1;
        bus.win          = 1'b0;
        bus.fail         = 1'b0;

        unique case (state_q)
            S_IDLE, S_WIN, S_FAIL: begin
                bus.busy = 1'b0;
                bus.win  = (state_q == S_WIN);
                bus.fail = (state_q == S_FAIL);
                if (bus.start) begin
                    state_d = S_CLEAR;
                    round_d = '0;
                    idx_d   = '0;
                end
            end
            S_CLEAR: begin
                bus.mem_rst = 1'b1;
                lane_d      = '0;
                state_d     = S_LOAD;
            end
            S_LOAD: begin
                bus.mem_load     = 1'b1;
                bus.mem_load_val = lane_q;
                bus.mem_in       = bus.rand_byte;
                lane_d           = lane_q + 2'd1;
                if (lane_q == 2'd3) begin
                    state_d = S_SHOW;
                    round_d = 5'd1;
                    idx_d   = '0;
                    phase_d = '0;
                end
            end
            S_SHOW: begin
                bus.show_valid = 1'b1;
                bus.show_sym   = exp_sym;
                if (phase_q == PH_W'(SHOW_CYCLES - 1)) begin
                    phase_d = '0;
                    state_d = S_GAP;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_GAP: begin
                if (phase_q == PH_W'(GAP_CYCLES - 1)) begin
                    phase_d = '0;
                    if (more) begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_SHOW;
                    end else begin
                        idx_d   = '0;
                        to_d    = '0;
                        state_d = S_INPUT;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_INPUT: begin
                if (bus.btn == 4'd0) begin
                    if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) state_d = S_FAIL;
                    else                                   to_d    = to_q + TO_W'(1);
                end else if (bus.btn != (4'b0001 << exp_sym)) begin
                    // Also catches multi-button presses, which are never one-hot
                    state_d = S_FAIL;
                end else if (more) begin
                    idx_d = idx_q + 4'd1;
                    to_d  = '0;
                end else if (round_q == 5'(MAX_ROUND)) begin
                    state_d = S_WIN;
                end else begin
                    round_d = round_q + 5'd1;
                    idx_d   = '0;
                    phase_d = '0;
                    state_d = S_SHOW;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Randomized self-checking bench for simon_seq_ctrl.
// Two instances are built: one with the default MAX_ROUND=16 and one with
// MAX_ROUND=2. Both share the same inputs. Each instance writes its own
// behavioural sequence register. The sel signal chooses which instance the
// checks observe.
module tb_simon_seq_ctrl;
    localparam int SHOW = 8;
    localparam int GAP  = 2;
    localparam int TMO  = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] rand_byte = 8'd0;
    logic [3:0] btn = 4'd0;
    logic       sel = 1'b0;
    int         n_checks = 0;
    int         n_pass = 0;

    logic [31:0] mem_a = 32'd0;
    logic [31:0] mem_b = 32'd0;

    simon_seq_if ia ();
    simon_seq_if ib ();

    assign ia.start = start;  assign ia.rand_byte = rand_byte;  assign ia.btn = btn;  assign ia.mem_data = mem_a;
    assign ib.start = start;  assign ib.rand_byte = rand_byte;  assign ib.btn = btn;  assign ib.mem_data = mem_b;

    simon_seq_ctrl #(.SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .MAX_ROUND(16), .TIMEOUT_CYCLES(TMO))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    simon_seq_ctrl #(.SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .MAX_ROUND(2), .TIMEOUT_CYCLES(TMO))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    always #5 clk = ~clk;

    // Behavioural sequence registers; rst_n deliberately not connected
    always @(posedge clk) begin
        if (ia.mem_rst) mem_a <= 32'd0;
        else if (ia.mem_load) mem_a[8*int'(ia.mem_load_val) +: 8] <= ia.mem_in;
        if (ib.mem_rst) mem_b <= 32'd0;
        else if (ib.mem_load) mem_b[8*int'(ib.mem_load_val) +: 8] <= ib.mem_in;
    end

    wire        o_mem_rst  = sel ? ib.mem_rst      : ia.mem_rst;
    wire        o_mem_load = sel ? ib.mem_load     : ia.mem_load;
    wire [1:0]  o_load_val = sel ? ib.mem_load_val : ia.mem_load_val;
    wire [7:0]  o_mem_in   = sel ? ib.mem_in       : ia.mem_in;
    wire        o_valid    = sel ? ib.show_valid   : ia.show_valid;
    wire [1:0]  o_sym      = sel ? ib.show_sym     : ia.show_sym;
    wire [4:0]  o_round    = sel ? ib.round        : ia.round;
    wire        o_busy     = sel ? ib.busy         : ia.busy;
    wire        o_win      = sel ? ib.win          : ia.win;
    wire        o_fail     = sel ? ib.fail         : ia.fail;
    wire [31:0] o_mem      = sel ? mem_b           : mem_a;
    wire [24:0] o_all      = {o_mem_rst, o_mem_load, o_load_val, o_mem_in, o_valid, o_sym,
                              o_round, o_busy, o_win, o_fail};

    // Reference: symbol i is bits 2i+1:2i of the 32-bit word made from the loaded bytes
    function automatic logic [1:0] sym_of(input logic [31:0] seq, input int i);
        return 2'((seq >> (2 * i)) & 32'h3);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (o_all !== 25'd0) $display("FAIL reset_low: outputs=%h want 0", o_all); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if ({o_busy, o_round, o_win, o_fail, o_valid} !== 9'd0)
            $display("FAIL reset_idle: busy/round/win/fail/valid=%b want 0", {o_busy, o_round, o_win, o_fail, o_valid});
        else n_pass++;
    endtask

    task automatic start_and_load(input logic [31:0] bytes);
        @(negedge clk);
        btn = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; #1;
        n_checks++;
        if ({o_mem_rst, o_mem_load, o_busy} !== 3'b101)
            $display("FAIL clear: rst/load/busy=%b want 101", {o_mem_rst, o_mem_load, o_busy});
        else n_pass++;
        for (int l = 0; l < 4; l++) begin
            @(negedge clk);
            rand_byte = bytes[8*l +: 8]; #1;
            n_checks++;
            if ({o_mem_rst, o_mem_load, o_load_val, o_mem_in} !== {1'b0, 1'b1, 2'(l), bytes[8*l +: 8]})
                $display("FAIL load lane%0d: rst/load/val/in=%b/%b/%0d/%h want 0/1/%0d/%h",
                         l, o_mem_rst, o_mem_load, o_load_val, o_mem_in, l, bytes[8*l +: 8]);
            else n_pass++;
        end
    endtask

    task automatic show_round(input int r, input logic [31:0] seq, input bit noise);
        for (int i = 0; i < r; i++) begin
            for (int c = 0; c < SHOW; c++) begin
                @(negedge clk);
                btn   = noise ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
                start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                rand_byte = 8'($urandom);
                #1;
                if (i == 0 && c == 0) begin
                    n_checks++;
                    if (o_mem !== seq) $display("FAIL mem_contents: got %h want %h", o_mem, seq); else n_pass++;
                end
                n_checks++;
                if ({o_valid, o_sym, o_round, o_busy} !== {1'b1, sym_of(seq, i), 5'(r), 1'b1})
                    $display("FAIL show r%0d i%0d c%0d: valid/sym/round/busy=%b/%0d/%0d/%b want 1/%0d/%0d/1",
                             r, i, c, o_valid, o_sym, o_round, o_busy, sym_of(seq, i), r);
                else n_pass++;
            end
            for (int g = 0; g < GAP; g++) begin
                @(negedge clk);
                btn = noise ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
                start = 1'b0; #1;
                n_checks++;
                if ({o_valid, o_sym, o_busy} !== 4'b0001)
                    $display("FAIL gap r%0d i%0d g%0d: valid/sym/busy=%b want 0001", r, i, g, {o_valid, o_sym, o_busy});
                else n_pass++;
            end
        end
    endtask

    // Idle for w cycles in INPUT (checking the game is still live), then press b for one cycle
    task automatic press(input logic [3:0] b, input int w);
        for (int c = 0; c < w; c++) begin
            @(negedge clk);
            btn = 4'd0; start = 1'b0; #1;
            n_checks++;
            if ({o_busy, o_fail, o_win, o_valid} !== 4'b1000)
                $display("FAIL input_wait c%0d: busy/fail/win/valid=%b want 1000", c, {o_busy, o_fail, o_win, o_valid});
            else n_pass++;
        end
        @(negedge clk);
        btn = b;
    endtask

    task automatic expect_end(input bit is_win, input int r);
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            btn = (h == 0) ? 4'd0 : 4'(1 << $urandom_range(0, 3)); #1;
            n_checks++;
            if ({o_win, o_fail, o_busy, o_round} !== {is_win, !is_win, 1'b0, 5'(r)})
                $display("FAIL end h%0d: win/fail/busy/round=%b/%b/%b/%0d want %b/%b/0/%0d",
                         h, o_win, o_fail, o_busy, o_round, is_win, !is_win, r);
            else n_pass++;
        end
        btn = 4'd0;
    endtask

    task automatic test_load_and_rounds();
        logic [31:0] seq = 32'h39C61BE4;
        start_and_load(seq);
        show_round(1, seq, 1'b0);
        press(4'b0001, 3);
        show_round(2, seq, 1'b0);
    endtask

    task automatic test_wrong_press();
        logic [31:0] seq = 32'h39C61BE4;
        logic [31:0] nseq = $urandom;
        press(4'b0001, 0);
        press(4'b0100, 0);
        expect_end(1'b0, 2);
        start_and_load(nseq);
        show_round(1, nseq, 1'b0);
        if (seq == 32'd0) $display("seq unused");
    endtask

    task automatic test_timeout();
        logic [31:0] seq = $urandom;
        for (int c = 0; c < TMO; c++) begin
            @(negedge clk);
            btn = 4'd0; #1;
            n_checks++;
            if ({o_fail, o_busy} !== 2'b01) $display("FAIL timeout_wait c%0d: fail/busy=%b want 01", c, {o_fail, o_busy});
            else n_pass++;
        end
        expect_end(1'b0, 1);
        start_and_load(seq);
        show_round(1, seq, 1'b0);
        press(4'b0011, 2);
        expect_end(1'b0, 1);
    endtask

    task automatic test_random_game();
        logic [31:0] seq = $urandom;
        start_and_load(seq);
        for (int r = 1; r <= 4; r++) begin
            show_round(r, seq, 1'b1);
            for (int i = 0; i < r; i++)
                press(4'(1 << sym_of(seq, i)), (i == 0 && r == 2) ? TMO - 1 : int'($urandom_range(0, 40)));
        end
        show_round(5, seq, 1'b1);
        press(4'(1 << ((int'(sym_of(seq, 0)) + 1) % 4)), 5);
        expect_end(1'b0, 5);
    endtask

    task automatic test_reset_mid_show();
        logic [31:0] seq = $urandom;
        start_and_load(seq);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_all !== 25'd0) $display("FAIL reset_mid_show: outputs=%h want 0", o_all); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if ({o_busy, o_round, o_valid} !== 7'd0)
            $display("FAIL reset_release: busy/round/valid=%b want 0", {o_busy, o_round, o_valid});
        else n_pass++;
    endtask

    task automatic test_win_max2();
        logic [31:0] seq = $urandom;
        logic [31:0] seq2 = $urandom;
        sel = 1'b1;
        start_and_load(seq);
        show_round(1, seq, 1'b1);
        press(4'(1 << sym_of(seq, 0)), 4);
        show_round(2, seq, 1'b1);
        press(4'(1 << sym_of(seq, 0)), 2);
        press(4'(1 << sym_of(seq, 1)), 7);
        expect_end(1'b1, 2);
        start_and_load(seq2);
        show_round(1, seq2, 1'b0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_and_rounds();
        test_wrong_press();
        test_timeout();
        test_random_game();
        test_reset_mid_show();
        test_win_max2();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
